axi_wr_arbiter: RTL and testbench

Two-master AXI4 write-channel arbiter in front of the single memory-mapped AXI4 slave. It shares the slave's AW/W/B channels between master 0 and master 1. Grants are per burst, round-robin, and held from the AW handshake through the B handshake. It also counts W beats against the captured AWLEN and generates the slave-side WLAST itself.

---
 rtl/axi_wr_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: shares one AXI4 slave write path (AW/W/B) between two
// masters. Ownership is granted per burst, round-robin, and held from the
// AW handshake through the B handshake. The slave-side WLAST comes from a
// beat counter loaded from AWLEN. The master's WLAST is only used to flag
// length mismatches.
module axi_wr_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESTN,
  // master 0
  input  logic [ADDR_WIDTH-1:0] M0_AWADDR,
  input  logic [7:0]            M0_AWLEN,
  input  logic [2:0]            M0_AWSIZE,
  input  logic                  M0_AWVALID,
  output logic                  M0_AWREADY,
  input  logic [DATA_WIDTH-1:0] M0_WDATA,
  input  logic                  M0_WLAST,
  input  logic                  M0_WVALID,
  output logic                  M0_WREADY,
  output logic [1:0]            M0_BRESP,
  output logic                  M0_BVALID,
  input  logic                  M0_BREADY,
  // master 1
  input  logic [ADDR_WIDTH-1:0] M1_AWADDR,
  input  logic [7:0]            M1_AWLEN,
  input  logic [2:0]            M1_AWSIZE,
  input  logic                  M1_AWVALID,
  output logic                  M1_AWREADY,
  input  logic [DATA_WIDTH-1:0] M1_WDATA,
  input  logic                  M1_WLAST,
  input  logic                  M1_WVALID,
  output logic                  M1_WREADY,
  output logic [1:0]            M1_BRESP,
  output logic                  M1_BVALID,
  input  logic                  M1_BREADY,
  // slave
  output logic [ADDR_WIDTH-1:0] S_AWADDR,
  output logic [7:0]            S_AWLEN,
  output logic [2:0]            S_AWSIZE,
  output logic                  S_AWVALID,
  input  logic                  S_AWREADY,
  output logic [DATA_WIDTH-1:0] S_WDATA,
  output logic                  S_WLAST,
  output logic                  S_WVALID,
  input  logic                  S_WREADY,
  input  logic [1:0]            S_BRESP,
  input  logic                  S_BVALID,
  output logic                  S_BREADY,
  // status
  output logic                  GRANT,
  output logic                  BUSY,
  output logic                  LEN_ERR
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] len_q, len_d;
  logic       len_err_q, len_err_d;

  // Request-side signals of whichever master currently holds the grant.
  logic [ADDR_WIDTH-1:0] g_awaddr;
  logic [7:0]            g_awlen;
  logic [2:0]            g_awsize;
  logic                  g_awvalid;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  g_wlast;
  logic                  g_wvalid;
  logic                  g_bready;

  logic       last_beat;
  logic       aw_hs, w_hs, b_hs;
  logic [1:0] awready, wready, bvalid;

  assign g_awaddr  = grant_q ? M1_AWADDR  : M0_AWADDR;
  assign g_awlen   = grant_q ? M1_AWLEN   : M0_AWLEN;
  assign g_awsize  = grant_q ? M1_AWSIZE  : M0_AWSIZE;
  assign g_awvalid = grant_q ? M1_AWVALID : M0_AWVALID;
  assign g_wdata   = grant_q ? M1_WDATA   : M0_WDATA;
  assign g_wlast   = grant_q ? M1_WLAST   : M0_WLAST;
  assign g_wvalid  = grant_q ? M1_WVALID  : M0_WVALID;
  assign g_bready  = grant_q ? M1_BREADY  : M0_BREADY;

  // The final beat is the one whose index equals the captured AWLEN.
  assign last_beat = (beat_cnt_q == len_q);
  assign aw_hs     = (state_q == ADDR) && g_awvalid && S_AWREADY;
  assign w_hs      = (state_q == DATA) && g_wvalid  && S_WREADY;
  assign b_hs      = (state_q == RESP) && S_BVALID  && g_bready;

  // State, grant, round-robin pointer, beat counter and error pulse registers
  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;   // so master 0 wins the first tie
      beat_cnt_q   <= '0;
      len_q        <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      len_err_q    <= len_err_d;
    end
  end

  // Next state: arbitrate in IDLE, capture AWLEN on AW, count beats, release on B
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    len_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant is registered here; AWREADY only follows once in ADDR.
        if (M0_AWVALID || M1_AWVALID) begin
          if (M0_AWVALID && M1_AWVALID) grant_d = ~last_grant_q;
          else                          grant_d = M1_AWVALID;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // A master dropping AWVALID early just leaves us waiting here.
        if (aw_hs) begin
          len_d      = g_awlen;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          len_err_d  = (g_wlast != last_beat);
          // The counter, not the master's WLAST, ends the burst.
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel routing: only the active channel of the granted master is connected
  always_comb begin
    S_AWADDR  = '0;
    S_AWLEN   = '0;
    S_AWSIZE  = '0;
    S_AWVALID = 1'b0;
    S_WDATA   = '0;
    S_WLAST   = 1'b0;
    S_WVALID  = 1'b0;
    S_BREADY  = 1'b0;
    awready   = '0;
    wready    = '0;
    bvalid    = '0;
    M0_BRESP  = '0;
    M1_BRESP  = '0;
    case (state_q)
      ADDR: begin
        S_AWADDR         = g_awaddr;
        S_AWLEN          = g_awlen;
        S_AWSIZE         = g_awsize;
        S_AWVALID        = g_awvalid;
        awready[grant_q] = S_AWREADY;
      end
      DATA: begin
        S_WDATA         = g_wdata;
        S_WVALID        = g_wvalid;
        S_WLAST         = last_beat;
        wready[grant_q] = S_WREADY;
      end
      RESP: begin
        S_BREADY        = g_bready;
        bvalid[grant_q] = S_BVALID;
        if (grant_q) M1_BRESP = S_BRESP;
        else         M0_BRESP = S_BRESP;
      end
      default: ;
    endcase
  end

  assign M0_AWREADY = awready[0];
  assign M1_AWREADY = awready[1];
  assign M0_WREADY  = wready[0];
  assign M1_WREADY  = wready[1];
  assign M0_BVALID  = bvalid[0];
  assign M1_BVALID  = bvalid[1];

  assign GRANT   = grant_q;
  assign BUSY    = (state_q != IDLE);
  assign LEN_ERR = len_err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: table of single-burst arbitration cases, hand
// sequences for stalls, early WLAST, preemption and reset, then a random
// two-master run scored against a transaction-level model.
module tb_axi_wr_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic ACLK = 1'b0;
  logic ARESTN = 1'b0;

  logic [1:0][AW-1:0] m_awaddr;
  logic [1:0][7:0]    m_awlen;
  logic [1:0][2:0]    m_awsize;
  logic [1:0]         m_awvalid, m_awready;
  logic [1:0][DW-1:0] m_wdata;
  logic [1:0]         m_wlast, m_wvalid, m_wready;
  logic [1:0][1:0]    m_bresp;
  logic [1:0]         m_bvalid, m_bready;

  logic [AW-1:0] S_AWADDR;
  logic [7:0]    S_AWLEN;
  logic [2:0]    S_AWSIZE;
  logic          S_AWVALID, s_awready;
  logic [DW-1:0] S_WDATA;
  logic          S_WLAST, S_WVALID, s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid, S_BREADY;
  logic          GRANT, BUSY, LEN_ERR;

  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_lerr;

  axi_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESTN(ARESTN),
    .M0_AWADDR(m_awaddr[0]), .M0_AWLEN(m_awlen[0]), .M0_AWSIZE(m_awsize[0]),
    .M0_AWVALID(m_awvalid[0]), .M0_AWREADY(m_awready[0]),
    .M0_WDATA(m_wdata[0]), .M0_WLAST(m_wlast[0]), .M0_WVALID(m_wvalid[0]),
    .M0_WREADY(m_wready[0]), .M0_BRESP(m_bresp[0]), .M0_BVALID(m_bvalid[0]),
    .M0_BREADY(m_bready[0]),
    .M1_AWADDR(m_awaddr[1]), .M1_AWLEN(m_awlen[1]), .M1_AWSIZE(m_awsize[1]),
    .M1_AWVALID(m_awvalid[1]), .M1_AWREADY(m_awready[1]),
    .M1_WDATA(m_wdata[1]), .M1_WLAST(m_wlast[1]), .M1_WVALID(m_wvalid[1]),
    .M1_WREADY(m_wready[1]), .M1_BRESP(m_bresp[1]), .M1_BVALID(m_bvalid[1]),
    .M1_BREADY(m_bready[1]),
    .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWVALID(S_AWVALID), .S_AWREADY(s_awready),
    .S_WDATA(S_WDATA), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(s_wready),
    .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(S_BREADY),
    .GRANT(GRANT), .BUSY(BUSY), .LEN_ERR(LEN_ERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic mid();
    @(negedge ACLK);
  endtask

  task automatic nx();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic outs_any();
    return |{S_AWADDR, S_AWLEN, S_AWSIZE, S_AWVALID, S_WDATA, S_WLAST, S_WVALID,
             S_BREADY, m_awready, m_wready, m_bresp, m_bvalid, GRANT, BUSY, LEN_ERR};
  endfunction

  task automatic clr_inputs();
    m_awaddr = '0; m_awlen = '0; m_awsize = {3'd2, 3'd2}; m_awvalid = '0;
    m_wdata = '0; m_wlast = '0; m_wvalid = '0; m_bready = 2'b11;
    s_awready = 1'b1; s_wready = 1'b1; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    ARESTN = 1'b0;
    clr_inputs();
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_outs", 32'(outs_any()), 0);
    ARESTN = 1'b1;
    nx();
  endtask

  // Arbitration cycle then the AW handshake; caller raises AWVALID first.
  task automatic do_addr(input logic g, input logic [7:0] len, input logic [15:0] addr);
    mid();
    chk("idle_no_aw", 32'({S_AWVALID, m_awready}), 0);
    chk("idle_busy", 32'(BUSY), 0);
    nx();
    mid();
    chk("grant", 32'(GRANT), 32'(g));
    chk("addr_busy", 32'(BUSY), 1);
    chk("s_awvalid", 32'(S_AWVALID), 1);
    chk("s_awaddr", 32'(S_AWADDR), 32'(addr));
    chk("s_awlen", 32'(S_AWLEN), 32'(len));
    chk("addr_no_w", 32'(S_WVALID), 0);
    chk("awready_g", 32'(m_awready[g]), 1);
    chk("awready_other", 32'(m_awready[!g]), 0);
    nx();
    m_awvalid[g] = 1'b0;
  endtask

  // Master WLAST is high from beat wl_at onward; other master requests at
  // raise_at; slave withholds WREADY for 3 cycles before beat stall_at.
  task automatic do_beats(input logic g, input int len, input logic [31:0] base,
                          input int wl_at, input int raise_at, input int stall_at);
    logic pend;
    pend = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (k == raise_at) m_awvalid[!g] = 1'b1;
      m_wvalid[g] = 1'b1;
      m_wdata[g]  = base + 32'(k);
      m_wlast[g]  = (k >= wl_at);
      if (k == stall_at) begin
        s_wready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          mid();
          chk("stall_busy", 32'(BUSY), 1);
          chk("stall_wready", 32'(m_wready[g]), 0);
          chk("stall_wdata", S_WDATA, base + 32'(k));
          chk("stall_wlast", 32'(S_WLAST), 32'(k == len));
          chk("stall_len_err", 32'(LEN_ERR), 32'(pend));
          pend = 1'b0;
          nx();
        end
        s_wready = 1'b1;
      end
      mid();
      chk("w_data", S_WDATA, base + 32'(k));
      chk("w_last", 32'(S_WLAST), 32'(k == len));
      chk("w_valid", 32'(S_WVALID), 1);
      chk("w_ready", 32'(m_wready[g]), 1);
      chk("other_quiet", 32'({m_awready[!g], m_wready[!g], m_bvalid[!g]}), 0);
      chk("len_err", 32'(LEN_ERR), 32'(pend));
      pend = ((k >= wl_at) != (k == len));
      nx();
    end
    m_wvalid[g] = 1'b0;
    m_wlast[g]  = 1'b0;
    exp_lerr    = pend;
  endtask

  task automatic do_resp(input logic g, input logic [1:0] resp, input int dly);
    logic pend;
    pend    = exp_lerr;
    s_bresp = resp;
    for (int c = 0; c < dly; c++) begin
      mid();
      chk("resp_wait_busy", 32'(BUSY), 1);
      chk("resp_wait_bvalid", 32'(m_bvalid[g]), 0);
      chk("resp_len_err", 32'(LEN_ERR), 32'(pend));
      pend = 1'b0;
      nx();
    end
    s_bvalid = 1'b1;
    mid();
    chk("b_valid", 32'(m_bvalid[g]), 1);
    chk("b_resp", 32'(m_bresp[g]), 32'(resp));
    chk("b_bready", 32'(S_BREADY), 1);
    chk("b_no_w", 32'(S_WVALID), 0);
    chk("b_other", 32'({m_awready[!g], m_wready[!g], m_bvalid[!g]}), 0);
    chk("b_len_err", 32'(LEN_ERR), 32'(pend));
    nx();
    s_bvalid = 1'b0;
  endtask

  function automatic logic [15:0] addr_of(input int m, input int b);
    return 16'(m * 'h4000 + b * 'h100 + 'h10);
  endfunction

  function automatic logic [31:0] dat_of(input int m, input int b, input int k);
    return 32'h5000_0000 + 32'(m << 20) + 32'(b << 12) + 32'(k);
  endfunction

  // Random two-master traffic. Masters re-request immediately after their B,
  // so while both have work the slave must see strictly alternating bursts.
  task automatic rand_test();
    int   nb[2];
    int   blen[2][16];
    int   mph[2], mb[2], mk[2];
    int   qm[$], qb[$];
    int   s_ph, s_m, s_b, s_k, s_len, s_dly, i0, i1, cyc;
    logic t;
    logic [1:0] s_rsp;
    logic [1:0] hs_w;
    logic m;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      nb[i] = 4 + int'($urandom % 5);
      for (int b = 0; b < 16; b++) blen[i][b] = int'($urandom % 6);
      mph[i] = 0; mb[i] = 0; mk[i] = 0;
    end
    i0 = 0; i1 = 0; t = 1'b0;
    while (i0 < nb[0] || i1 < nb[1]) begin
      if (i0 < nb[0] && (!t || i1 >= nb[1])) begin
        qm.push_back(0); qb.push_back(i0); i0++; t = 1'b1;
      end else begin
        qm.push_back(1); qb.push_back(i1); i1++; t = 1'b0;
      end
    end
    s_ph = 0; s_m = 0; s_b = 0; s_k = 0; s_len = 0; s_dly = 0; s_rsp = '0;
    hs_w = '0; cyc = 0;
    while (!(mph[0] == 3 && mph[1] == 3 && s_ph == 0) && cyc < 4000) begin
      for (int i = 0; i < 2; i++) begin
        m = i[0];
        m_awvalid[m] = (mph[i] == 0);
        m_awaddr[m]  = addr_of(i, mb[i]);
        m_awlen[m]   = 8'(blen[i][mb[i]]);
        if (mph[i] != 1)                 m_wvalid[m] = 1'b0;
        else if (hs_w[m] || !m_wvalid[m]) m_wvalid[m] = (($urandom % 4) != 0);
        m_wdata[m]  = dat_of(i, mb[i], mk[i]);
        m_wlast[m]  = (mk[i] == blen[i][mb[i]]);
        m_bready[m] = (($urandom % 3) != 0);
      end
      s_awready = 1'($urandom % 2);
      s_wready  = (($urandom % 4) != 0);
      if (s_ph == 2) begin
        if (s_dly == 0) s_ph = 3;
        else s_dly--;
      end
      s_bvalid = (s_ph == 3);
      s_bresp  = s_rsp;
      mid();
      chk("r_exclusive", 32'((m_awready[0] | m_wready[0] | m_bvalid[0]) &
                             (m_awready[1] | m_wready[1] | m_bvalid[1])), 0);
      chk("r_len_err", 32'(LEN_ERR), 0);
      hs_w = '0;
      if (S_BREADY && s_bvalid) s_ph = 0;
      if (S_AWVALID && s_awready) begin
        chk("r_aw_after_b", 32'(s_ph), 0);
        if (qm.size() > 0) begin
          chk("r_aw_addr", 32'(S_AWADDR), 32'(addr_of(qm[0], qb[0])));
          chk("r_aw_len", 32'(S_AWLEN), 32'(blen[qm[0]][qb[0]]));
          s_m = qm.pop_front();
          s_b = qb.pop_front();
          s_len = blen[s_m][s_b];
        end
        s_ph = 1; s_k = 0; s_rsp = 2'($urandom % 4);
      end
      if (S_WVALID && s_wready) begin
        chk("r_w_phase", 32'(s_ph), 1);
        chk("r_w_data", S_WDATA, dat_of(s_m, s_b, s_k));
        chk("r_w_last", 32'(S_WLAST), 32'(s_k == s_len));
        if (s_k == s_len) begin s_ph = 2; s_dly = int'($urandom % 4); end
        else s_k++;
      end
      for (int i = 0; i < 2; i++) begin
        m = i[0];
        if (m_awvalid[m] && m_awready[m]) begin
          chk("r_aw_owner", 32'(i), 32'(s_m));
          mph[i] = 1; mk[i] = 0;
        end
        if (m_wvalid[m] && m_wready[m]) begin
          hs_w[m] = 1'b1;
          if (mk[i] == blen[i][mb[i]]) mph[i] = 2;
          else mk[i]++;
        end
        if (m_bvalid[m] && m_bready[m]) begin
          chk("r_b_resp", 32'(m_bresp[m]), 32'(s_rsp));
          chk("r_b_owner", 32'(i), 32'(s_m));
          mb[i]++;
          mph[i] = (mb[i] < nb[i]) ? 0 : 3;
        end
      end
      nx();
      cyc++;
    end
    chk("r_all_done", 32'(mph[0] == 3 && mph[1] == 3 && s_ph == 0), 1);
    chk("r_queue_empty", 32'(qm.size()), 0);
    clr_inputs();
  endtask

  typedef struct {
    logic        req0;
    logic        req1;
    logic [7:0]  len;
    logic [15:0] addr;
    logic [31:0] base;
    logic [1:0]  resp;
    logic        gnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'd3, 16'h0010, 32'hA0,  2'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'd0, 16'h0100, 32'hB0,  2'd1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'd0, 16'h0200, 32'hC0,  2'd2, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'd0, 16'h0300, 32'hD0,  2'd3, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'd0, 16'h0400, 32'hE0,  2'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'd1, 16'h0500, 32'hF0,  2'd1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'd2, 16'h0600, 32'h100, 2'd2, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'd1, 16'h0700, 32'h110, 2'd3, 1'b0};
    exp_lerr = 1'b0;

    do_reset();
    chk("rst_grant", 32'(GRANT), 0);

    // single bursts: round-robin decisions with and without contention
    for (int i = 0; i < 8; i++) begin
      m_awvalid[0] = tbl[i].req0;
      m_awvalid[1] = tbl[i].req1;
      m_awaddr[0] = tbl[i].addr; m_awaddr[1] = tbl[i].addr;
      m_awlen[0]  = tbl[i].len;  m_awlen[1]  = tbl[i].len;
      do_addr(tbl[i].gnt, tbl[i].len, tbl[i].addr);
      do_beats(tbl[i].gnt, int'(tbl[i].len), tbl[i].base, int'(tbl[i].len), -1, -1);
      do_resp(tbl[i].gnt, tbl[i].resp, 0);
      m_awvalid = 2'b00;
    end

    // M1 holds the channel for 8 beats while M0 waits from beat 2
    m_awvalid[1] = 1'b1; m_awaddr[1] = 16'h1230; m_awlen[1] = 8'd7;
    m_awaddr[0] = 16'h0450; m_awlen[0] = 8'd0;
    do_addr(1'b1, 8'd7, 16'h1230);
    do_beats(1'b1, 7, 32'h300, 7, 2, -1);
    do_resp(1'b1, 2'd2, 0);
    do_addr(1'b0, 8'd0, 16'h0450);
    do_beats(1'b0, 0, 32'h400, 0, -1, -1);
    do_resp(1'b0, 2'd0, 0);

    // early master WLAST on beat 2 of 3: one LEN_ERR, burst still 3 beats
    m_awvalid[0] = 1'b1; m_awaddr[0] = 16'h0800; m_awlen[0] = 8'd2;
    do_addr(1'b0, 8'd2, 16'h0800);
    do_beats(1'b0, 2, 32'h500, 1, -1, -1);
    do_resp(1'b0, 2'd1, 0);
    mid();
    chk("len_err_cleared", 32'(LEN_ERR), 0);
    nx();

    // W stall of 3 cycles mid-burst and a late B response
    m_awvalid[1] = 1'b1; m_awaddr[1] = 16'h0900; m_awlen[1] = 8'd4;
    do_addr(1'b1, 8'd4, 16'h0900);
    do_beats(1'b1, 4, 32'h600, 4, -1, 2);
    do_resp(1'b1, 2'd3, 5);

    // reset in DATA after 2 of 4 beats, then only M1 requests
    m_awvalid[0] = 1'b1; m_awaddr[0] = 16'h0A00; m_awlen[0] = 8'd3;
    do_addr(1'b0, 8'd3, 16'h0A00);
    for (int k = 0; k < 2; k++) begin
      m_wvalid[0] = 1'b1; m_wdata[0] = 32'h700 + 32'(k); m_wlast[0] = 1'b0;
      mid();
      chk("pre_rst_wdata", S_WDATA, 32'h700 + 32'(k));
      nx();
    end
    m_wdata[0] = 32'h702;
    ARESTN = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs_any()), 0);
    clr_inputs();
    mid();
    ARESTN = 1'b1;
    nx();
    m_awvalid[1] = 1'b1; m_awaddr[1] = 16'h0B00; m_awlen[1] = 8'd1;
    do_addr(1'b1, 8'd1, 16'h0B00);
    do_beats(1'b1, 1, 32'h800, 1, -1, -1);
    do_resp(1'b1, 2'd0, 0);

    rand_test();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
